// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner: shows NUM_DIGITS hex nibbles on one shared
// segment bus, with per-frame input snapshots, dead time, zero suppression and blink.
module seven_seg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int DEAD_CYCLES    = 16,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_suppress,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_start
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEAD_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_ON   = (SEG_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic                  DP_OFF  = ~DP_ON;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]             presc_reg;
    logic [IW-1:0]             digit_idx_reg;
    logic [DW-1:0]             dead_reg;
    logic [FW-1:0]             frame_cnt_reg;
    logic                      blink_phase_reg;
    logic [4*NUM_DIGITS-1:0]   snap_data_reg;
    logic [NUM_DIGITS-1:0]     snap_dp_reg;
    logic [NUM_DIGITS-1:0]     snap_blink_reg;
    logic                      snap_lz_reg;
    logic [6:0]                seg_reg;
    logic                      dp_reg;
    logic [NUM_DIGITS-1:0]     an_reg;
    logic                      frame_start_reg;

    logic                      tick;
    logic                      wrap;
    logic [3:0]                nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     lead_zero;
    logic [NUM_DIGITS-1:0]     blank;
    logic [NUM_DIGITS-1:0]     an_sel;
    logic [6:0]                seg_next;
    logic                      dp_next;
    logic [NUM_DIGITS-1:0]     an_next;

    // Active-low glyph table, bit6..bit0 = g..a.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] p;
        p = 7'h7F;
        case (v)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            4'hF: p = 7'h0E;
        endcase
        return p;
    endfunction

    assign tick = (presc_reg == PRESC_LAST);
    assign wrap = tick && (digit_idx_reg == IDX_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi] = snap_data_reg[4*gi +: 4];
            // A digit is a leading zero when it and every more significant nibble are zero.
            if (gi == 0) begin : g_lsd
                assign lead_zero[gi] = 1'b0;
            end else begin : g_upper
                assign lead_zero[gi] = snap_lz_reg && (snap_data_reg[4*NUM_DIGITS-1:4*gi] == '0);
            end
            assign blank[gi]  = (snap_blink_reg[gi] && blink_phase_reg) || lead_zero[gi];
            assign an_sel[gi] = (dead_reg == '0) && (digit_idx_reg == IW'(gi));
        end
    endgenerate

    always_comb begin
        seg_next = SEG_OFF;
        dp_next  = DP_OFF;
        an_next  = (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;
        // Segment bus stays dark during dead time so the previous glyph cannot ghost.
        if ((dead_reg == '0) && !blank[digit_idx_reg]) begin
            seg_next = (SEG_ACTIVE_LOW != 0) ? decode(nib[digit_idx_reg]) : ~decode(nib[digit_idx_reg]);
            dp_next  = snap_dp_reg[digit_idx_reg] ? DP_ON : DP_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg       <= '0;
            digit_idx_reg   <= '0;
            dead_reg        <= DEAD_LOAD;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            snap_data_reg   <= '0;
            snap_dp_reg     <= '0;
            snap_blink_reg  <= '0;
            snap_lz_reg     <= 1'b0;
            seg_reg         <= SEG_OFF;
            dp_reg          <= DP_OFF;
            an_reg          <= AN_OFF;
            frame_start_reg <= 1'b0;
        end else begin
            if (tick) begin
                presc_reg     <= '0;
                digit_idx_reg <= wrap ? '0 : digit_idx_reg + 1'b1;
                dead_reg      <= DEAD_LOAD;
            end else begin
                presc_reg <= presc_reg + 1'b1;
                if (dead_reg != '0) begin
                    dead_reg <= dead_reg - 1'b1;
                end
            end

            frame_start_reg <= wrap;
            // Inputs are frozen once per frame so a multi-digit value never tears.
            if (wrap) begin
                snap_data_reg  <= data_in;
                snap_dp_reg    <= dp_in;
                snap_blink_reg <= blink_mask;
                snap_lz_reg    <= lz_suppress;
                if (frame_cnt_reg == FRAME_LAST) begin
                    frame_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end

            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            an_reg  <= an_next;
        end
    end

    assign seg_out     = seg_reg;
    assign dp_out      = dp_reg;
    assign an_out      = an_reg;
    assign frame_start = frame_start_reg;

endmodule
